// File: rtl/roce_rc_ack_responder.sv
// RoCEv2 RC responder for RDMA WRITE on one QP: checks PSN and opcode order, tracks ePSN/MSN,
// and emits ACK/NAK header descriptors through a single-entry output register.
module roce_rc_ack_responder #(
  parameter int unsigned ACK_COALESCE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_qp_valid,
  input  logic [23:0] cfg_local_qpn,
  input  logic [23:0] cfg_rem_qpn,
  input  logic [23:0] cfg_start_psn,
  input  logic        s_hdr_valid,
  output logic        s_hdr_ready,
  input  logic [7:0]  s_hdr_opcode,
  input  logic [23:0] s_hdr_dest_qp,
  input  logic [23:0] s_hdr_psn,
  input  logic        s_hdr_ack_req,
  output logic        m_ack_valid,
  input  logic        m_ack_ready,
  output logic [7:0]  m_ack_opcode,
  output logic [23:0] m_ack_dest_qp,
  output logic [23:0] m_ack_psn,
  output logic [7:0]  m_ack_syndrome,
  output logic [23:0] m_ack_msn,
  output logic [15:0] stat_drop_cnt
);

  localparam logic [7:0]  OP_FIRST     = 8'h06;
  localparam logic [7:0]  OP_MIDDLE    = 8'h07;
  localparam logic [7:0]  OP_LAST      = 8'h08;
  localparam logic [7:0]  OP_LAST_IMD  = 8'h09;
  localparam logic [7:0]  OP_ONLY      = 8'h0A;
  localparam logic [7:0]  OP_ONLY_IMD  = 8'h0B;
  localparam logic [7:0]  OP_RC_ACK    = 8'h11;
  localparam logic [7:0]  SYN_ACK      = 8'h1F;
  localparam logic [7:0]  SYN_NAK_SEQ  = 8'h60;
  localparam logic [7:0]  SYN_NAK_INV  = 8'h61;
  localparam logic [15:0] COAL_LIMIT   = 16'(ACK_COALESCE);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MID  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] epsn_q, epsn_d;
  logic [23:0] msn_q, msn_d;
  logic        nak_sent_q, nak_sent_d;
  logic [15:0] coal_cnt_q, coal_cnt_d;
  logic [15:0] stat_q, stat_d;
  logic        ready_en_q;

  logic        ack_valid_q, ack_valid_d;
  logic [7:0]  ack_opcode_q, ack_opcode_d;
  logic [23:0] ack_dest_q, ack_dest_d;
  logic [23:0] ack_psn_q, ack_psn_d;
  logic [7:0]  ack_syn_q, ack_syn_d;
  logic [23:0] ack_msn_q, ack_msn_d;

  logic        accept;
  logic        hdr_ok;
  logic [23:0] psn_diff;
  logic        is_first, is_middle, is_last, is_only, is_end;
  logic        op_legal;
  logic [15:0] coal_inc;
  logic        gen;
  logic [7:0]  gen_syn;
  logic [23:0] gen_psn;
  logic        stat_inc;

  // Handshake: a descriptor is taken on s_hdr_valid & s_hdr_ready. The ACK register frees up
  // when empty or draining this cycle, so s_hdr_ready = !m_ack_valid | m_ack_ready (always 1
  // while the QP is flushed, always 0 until the first clock after reset). m_ack_* stay stable
  // while m_ack_valid & !m_ack_ready.
  assign s_hdr_ready = ready_en_q & (~cfg_qp_valid | ~ack_valid_q | m_ack_ready);
  assign accept      = s_hdr_valid & s_hdr_ready;

  assign hdr_ok    = (s_hdr_dest_qp == cfg_local_qpn) &&
                     (s_hdr_opcode >= OP_FIRST) && (s_hdr_opcode <= OP_ONLY_IMD);
  assign psn_diff  = s_hdr_psn - epsn_q;
  assign is_first  = (s_hdr_opcode == OP_FIRST);
  assign is_middle = (s_hdr_opcode == OP_MIDDLE);
  assign is_last   = (s_hdr_opcode == OP_LAST) || (s_hdr_opcode == OP_LAST_IMD);
  assign is_only   = (s_hdr_opcode == OP_ONLY) || (s_hdr_opcode == OP_ONLY_IMD);
  assign is_end    = is_last | is_only;
  assign op_legal  = (state_q == ST_IDLE) ? (is_first | is_only) : (is_middle | is_last);
  assign coal_inc  = coal_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    epsn_d     = epsn_q;
    msn_d      = msn_q;
    nak_sent_d = nak_sent_q;
    coal_cnt_d = coal_cnt_q;
    gen        = 1'b0;
    gen_syn    = SYN_ACK;
    gen_psn    = s_hdr_psn;
    stat_inc   = 1'b0;

    if (!cfg_qp_valid) begin
      state_d    = ST_IDLE;
      epsn_d     = cfg_start_psn;
      msn_d      = 24'd0;
      nak_sent_d = 1'b0;
      coal_cnt_d = 16'd0;
    end else if (accept) begin
      if (!hdr_ok) begin
        stat_inc = 1'b1;
      end else if (psn_diff == 24'd0) begin
        if (op_legal) begin
          epsn_d     = epsn_q + 24'd1;
          nak_sent_d = 1'b0;
          if (is_end) begin
            msn_d = msn_q + 24'd1;
          end
          state_d = (is_first | is_middle) ? ST_MID : ST_IDLE;
          if (s_hdr_ack_req || is_end || (coal_inc == COAL_LIMIT)) begin
            gen        = 1'b1;
            gen_syn    = SYN_ACK;
            gen_psn    = s_hdr_psn;
            coal_cnt_d = 16'd0;
          end else begin
            coal_cnt_d = coal_inc;
          end
        end else begin
          gen      = 1'b1;
          gen_syn  = SYN_NAK_INV;
          gen_psn  = epsn_q;
          state_d  = ST_IDLE;
          stat_inc = 1'b1;
        end
      end else if (!psn_diff[23]) begin
        // Future PSN: only the first out-of-sequence packet earns a NAK until ePSN arrives.
        stat_inc = 1'b1;
        if (!nak_sent_q) begin
          gen        = 1'b1;
          gen_syn    = SYN_NAK_SEQ;
          gen_psn    = epsn_q;
          nak_sent_d = 1'b1;
        end
      end else begin
        gen     = 1'b1;
        gen_syn = SYN_ACK;
        gen_psn = epsn_q - 24'd1;
      end
    end
  end

  always_comb begin
    ack_valid_d  = ack_valid_q & ~m_ack_ready;
    ack_opcode_d = ack_opcode_q;
    ack_dest_d   = ack_dest_q;
    ack_psn_d    = ack_psn_q;
    ack_syn_d    = ack_syn_q;
    ack_msn_d    = ack_msn_q;
    stat_d       = stat_q;

    if (!cfg_qp_valid) begin
      ack_valid_d = 1'b0;
    end else if (gen) begin
      ack_valid_d  = 1'b1;
      ack_opcode_d = OP_RC_ACK;
      ack_dest_d   = cfg_rem_qpn;
      ack_psn_d    = gen_psn;
      ack_syn_d    = gen_syn;
      ack_msn_d    = msn_d;
    end

    if (stat_inc && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      epsn_q       <= 24'd0;
      msn_q        <= 24'd0;
      nak_sent_q   <= 1'b0;
      coal_cnt_q   <= 16'd0;
      stat_q       <= 16'd0;
      ready_en_q   <= 1'b0;
      ack_valid_q  <= 1'b0;
      ack_opcode_q <= 8'd0;
      ack_dest_q   <= 24'd0;
      ack_psn_q    <= 24'd0;
      ack_syn_q    <= 8'd0;
      ack_msn_q    <= 24'd0;
    end else begin
      state_q      <= state_d;
      epsn_q       <= epsn_d;
      msn_q        <= msn_d;
      nak_sent_q   <= nak_sent_d;
      coal_cnt_q   <= coal_cnt_d;
      stat_q       <= stat_d;
      ready_en_q   <= 1'b1;
      ack_valid_q  <= ack_valid_d;
      ack_opcode_q <= ack_opcode_d;
      ack_dest_q   <= ack_dest_d;
      ack_psn_q    <= ack_psn_d;
      ack_syn_q    <= ack_syn_d;
      ack_msn_q    <= ack_msn_d;
    end
  end

  assign m_ack_valid    = ack_valid_q;
  assign m_ack_opcode   = ack_opcode_q;
  assign m_ack_dest_qp  = ack_dest_q;
  assign m_ack_psn      = ack_psn_q;
  assign m_ack_syndrome = ack_syn_q;
  assign m_ack_msn      = ack_msn_q;
  assign stat_drop_cnt  = stat_q;

endmodule

// File: tb/tb_roce_rc_ack_responder.sv
// Bench for roce_rc_ack_responder: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level responder model.
module tb_roce_rc_ack_responder;

  localparam int          COAL = 4;
  localparam logic [23:0] LQPN = 24'h123456;
  localparam logic [23:0] RQPN = 24'hABCDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_qp_valid;
  logic [23:0] cfg_local_qpn, cfg_rem_qpn, cfg_start_psn;
  logic        s_hdr_valid, s_hdr_ready;
  logic [7:0]  s_hdr_opcode;
  logic [23:0] s_hdr_dest_qp, s_hdr_psn;
  logic        s_hdr_ack_req;
  logic        m_ack_valid, m_ack_ready;
  logic [7:0]  m_ack_opcode, m_ack_syndrome;
  logic [23:0] m_ack_dest_qp, m_ack_psn, m_ack_msn;
  logic [15:0] stat_drop_cnt;

  always #5 clk = ~clk;

  roce_rc_ack_responder #(.ACK_COALESCE(COAL)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_qp_valid(cfg_qp_valid),
    .cfg_local_qpn(cfg_local_qpn), .cfg_rem_qpn(cfg_rem_qpn), .cfg_start_psn(cfg_start_psn),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr_opcode(s_hdr_opcode),
    .s_hdr_dest_qp(s_hdr_dest_qp), .s_hdr_psn(s_hdr_psn), .s_hdr_ack_req(s_hdr_ack_req),
    .m_ack_valid(m_ack_valid), .m_ack_ready(m_ack_ready), .m_ack_opcode(m_ack_opcode),
    .m_ack_dest_qp(m_ack_dest_qp), .m_ack_psn(m_ack_psn), .m_ack_syndrome(m_ack_syndrome),
    .m_ack_msn(m_ack_msn), .stat_drop_cnt(stat_drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected ACK register contents: {dest_qp, psn, syndrome, msn}
  logic [79:0] exp_q[$];
  logic [23:0] m_epsn, m_msn;
  bit          m_in_msg, m_nak, m_rdone;
  int          m_cnt, m_stat;
  bit          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_epsn = 24'd0; m_msn = 24'd0; m_in_msg = 0; m_nak = 0; m_cnt = 0; m_stat = 0; m_rdone = 0;
  endtask

  task automatic model_push(input logic [23:0] p, input logic [7:0] syn);
    exp_q.push_back({cfg_rem_qpn, p, syn, m_msn});
  endtask

  task automatic model_drop();
    if (m_stat < 65535) m_stat++;
  endtask

  // Applies one descriptor's worth of responder rules at transaction level.
  task automatic model_step(input bit acc, input logic [7:0] op, input logic [23:0] dq,
                            input logic [23:0] psn, input bit ar, input bit rdy);
    logic [23:0] d;
    bit legal, fin;
    if (!cfg_qp_valid) begin
      m_epsn = cfg_start_psn; m_msn = 24'd0; m_in_msg = 0; m_nak = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
      if (acc) begin
        d = psn - m_epsn;
        if (dq != cfg_local_qpn || op < 8'h06 || op > 8'h0B) begin
          model_drop();
        end else if (d == 24'd0) begin
          if (m_in_msg) legal = (op == 8'h07 || op == 8'h08 || op == 8'h09);
          else          legal = (op == 8'h06 || op == 8'h0A || op == 8'h0B);
          if (legal) begin
            fin = (op >= 8'h08);
            if (fin) m_msn = m_msn + 24'd1;
            m_in_msg = (op == 8'h06 || op == 8'h07);
            m_epsn = m_epsn + 24'd1;
            m_nak = 0;
            m_cnt++;
            if (ar || fin || m_cnt == COAL) begin
              model_push(psn, 8'h1F);
              m_cnt = 0;
            end
          end else begin
            model_push(m_epsn, 8'h61);
            m_in_msg = 0;
            model_drop();
          end
        end else if (d < 24'h800000) begin
          if (!m_nak) begin
            model_push(m_epsn, 8'h60);
            m_nak = 1;
          end
          model_drop();
        end else begin
          model_push(m_epsn - 24'd1, 8'h1F);
        end
      end
    end
  endtask

  // One clock: drive inputs, compare DUT with model, advance model, step to the next negedge.
  task automatic cycle(input bit v, input logic [7:0] op, input logic [23:0] dq,
                       input logic [23:0] psn, input bit ar, input bit rdy);
    logic [79:0] e;
    bit exp_rdy;
    s_hdr_valid = v; s_hdr_opcode = op; s_hdr_dest_qp = dq; s_hdr_psn = psn;
    s_hdr_ack_req = ar; m_ack_ready = rdy;
    #1;
    exp_rdy = m_rdone && (!cfg_qp_valid || exp_q.size() == 0 || rdy);
    chk("s_hdr_ready", 32'(s_hdr_ready), 32'(exp_rdy));
    chk("stat_drop_cnt", 32'(stat_drop_cnt), 32'(m_stat));
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("m_ack_valid", 32'(m_ack_valid), 32'd1);
      chk("m_ack_opcode", 32'(m_ack_opcode), 32'h11);
      chk("m_ack_dest_qp", 32'(m_ack_dest_qp), 32'(e[79:56]));
      chk("m_ack_psn", 32'(m_ack_psn), 32'(e[55:32]));
      chk("m_ack_syndrome", 32'(m_ack_syndrome), 32'(e[31:24]));
      chk("m_ack_msn", 32'(m_ack_msn), 32'(e[23:0]));
    end else begin
      chk("m_ack_valid_idle", 32'(m_ack_valid), 32'd0);
    end
    last_acc = v && exp_rdy;
    model_step(last_acc, op, dq, psn, ar, rdy);
    @(posedge clk);
    m_rdone = 1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] op, input logic [23:0] psn, input bit ar);
    cycle(1'b1, op, cfg_local_qpn, psn, ar, 1'b1);
  endtask

  task automatic flush(input logic [23:0] start);
    cfg_qp_valid = 1'b0; cfg_start_psn = start;
    cycle(1'b0, 8'h00, 24'd0, 24'd0, 1'b0, 1'b1);
    cfg_qp_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m_ack_valid", 32'(m_ack_valid), 32'd0);
    chk("rst_s_hdr_ready", 32'(s_hdr_ready), 32'd0);
    chk("rst_stat", 32'(stat_drop_cnt), 32'd0);
    chk("rst_opcode", 32'(m_ack_opcode), 32'd0);
    chk("rst_psn", 32'(m_ack_psn), 32'd0);
    chk("rst_msn", 32'(m_ack_msn), 32'd0);
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  op;
    logic [23:0] p, dq;
    int k, r;
    cfg_qp_valid = 1'b0; cfg_local_qpn = LQPN; cfg_rem_qpn = RQPN; cfg_start_psn = 24'h000010;
    s_hdr_valid = 1'b0; s_hdr_opcode = 8'h00; s_hdr_dest_qp = 24'd0; s_hdr_psn = 24'd0;
    s_hdr_ack_req = 1'b0; m_ack_ready = 1'b1;
    model_reset();
    do_reset();

    // WRITE_ONLY in order with AckReq
    flush(24'h000010);
    send(8'h0A, 24'h000010, 1'b1);
    chk("only_valid", 32'(m_ack_valid), 32'd1);
    chk("only_psn", 32'(m_ack_psn), 32'h10);
    chk("only_syn", 32'(m_ack_syndrome), 32'h1F);
    chk("only_msn", 32'(m_ack_msn), 32'd1);
    chk("only_dest", 32'(m_ack_dest_qp), 32'(RQPN));

    // Coalescing: FIRST + 5x MIDDLE without AckReq, one ACK at the 4th packet
    flush(24'h000000);
    send(8'h06, 24'd0, 1'b0);
    chk("coal_first", 32'(m_ack_valid), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      send(8'h07, 24'(i), 1'b0);
      chk("coal_valid", 32'(m_ack_valid), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) chk("coal_psn", 32'(m_ack_psn), 32'd3);
    end

    // Future PSNs: a single sequence NAK, cleared by the in-order packet
    flush(24'h000020);
    send(8'h0A, 24'h000022, 1'b0);
    chk("nak_syn", 32'(m_ack_syndrome), 32'h60);
    chk("nak_psn", 32'(m_ack_psn), 32'h20);
    send(8'h0A, 24'h000023, 1'b0);
    chk("nak_silent", 32'(m_ack_valid), 32'd0);
    send(8'h0A, 24'h000020, 1'b0);
    chk("nak_recover_syn", 32'(m_ack_syndrome), 32'h1F);
    chk("nak_recover_psn", 32'(m_ack_psn), 32'h20);
    send(8'h0A, 24'h000022, 1'b0);
    chk("nak_again_syn", 32'(m_ack_syndrome), 32'h60);
    chk("nak_again_psn", 32'(m_ack_psn), 32'h21);

    // PSN wrap and duplicate across the wrap
    flush(24'hFFFFFF);
    send(8'h0A, 24'hFFFFFF, 1'b0);
    chk("wrap_psn", 32'(m_ack_psn), 32'hFFFFFF);
    send(8'h0A, 24'hFFFFFE, 1'b0);
    chk("dup_valid", 32'(m_ack_valid), 32'd1);
    chk("dup_syn", 32'(m_ack_syndrome), 32'h1F);
    chk("dup_psn", 32'(m_ack_psn), 32'hFFFFFF);
    chk("dup_msn", 32'(m_ack_msn), 32'd1);

    // Opcode-order violation, foreign QP, and unsupported opcode
    chk("stat_before", 32'(stat_drop_cnt), 32'd3);
    send(8'h07, 24'h000000, 1'b0);
    chk("inv_syn", 32'(m_ack_syndrome), 32'h61);
    chk("inv_psn", 32'(m_ack_psn), 32'h0);
    chk("inv_stat", 32'(stat_drop_cnt), 32'd4);
    cycle(1'b1, 8'h0A, LQPN ^ 24'h1, 24'h000000, 1'b1, 1'b1);
    chk("qp_drop_valid", 32'(m_ack_valid), 32'd0);
    chk("qp_drop_stat", 32'(stat_drop_cnt), 32'd5);
    send(8'h04, 24'h000000, 1'b1);
    chk("op_drop_stat", 32'(stat_drop_cnt), 32'd6);

    // Back-pressure: 3 queued descriptors, ACK held 10 cycles
    flush(24'h000040);
    k = 0;
    for (int c = 0; c < 30 && k < 3; c++) begin
      cycle(1'b1, 8'h0A, cfg_local_qpn, 24'h000040 + 24'(k), 1'b1, c >= 10);
      if (last_acc) k++;
      if (c < 9) begin
        chk("bp_ready_low", 32'(s_hdr_ready), 32'd0);
        chk("bp_hold_psn", 32'(m_ack_psn), 32'h40);
        chk("bp_hold_valid", 32'(m_ack_valid), 32'd1);
      end
    end
    chk("bp_all_accepted", 32'(k), 32'd3);
    repeat (2) cycle(1'b0, 8'h00, 24'd0, 24'd0, 1'b0, 1'b1);

    // Reset with an ACK pending
    cycle(1'b1, 8'h0A, cfg_local_qpn, 24'h000043, 1'b1, 1'b0);
    chk("mid_pending", 32'(m_ack_valid), 32'd1);
    do_reset();
    flush(24'hFFFFF8);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) == 0) begin
        cfg_qp_valid = 1'b0;
        cfg_start_psn = ($urandom_range(1) == 1) ? 24'hFFFFF0 + 24'($urandom_range(15)) : 24'($urandom);
      end else begin
        cfg_qp_valid = 1'b1;
      end
      if ($urandom_range(9) == 0) op = 8'($urandom_range(15));
      else if (m_in_msg) begin
        r = $urandom_range(3);
        op = (r < 2) ? 8'h07 : ((r == 2) ? 8'h08 : 8'h09);
      end else begin
        r = $urandom_range(2);
        op = (r == 0) ? 8'h06 : ((r == 1) ? 8'h0A : 8'h0B);
      end
      r = $urandom_range(99);
      if (r < 65)      p = m_epsn;
      else if (r < 80) p = m_epsn + 24'($urandom_range(1, 4));
      else if (r < 95) p = m_epsn - 24'($urandom_range(1, 4));
      else             p = 24'($urandom);
      dq = ($urandom_range(19) == 0) ? (LQPN ^ 24'h10) : LQPN;
      cycle($urandom_range(99) < 70, op, dq, p, $urandom_range(3) == 0, $urandom_range(99) < 75);
    end
    cfg_qp_valid = 1'b1;
    repeat (4) cycle(1'b0, 8'h00, 24'd0, 24'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
